// File: rtl/concurrent_fifo_sync_flags.sv
// rtl/concurrent_fifo_sync_flags.sv - single-clock FIFO with fill count, threshold flags, sticky errors, optional FWFT
module concurrent_fifo_sync_flags #(
    parameter int DATA_WIDTH          = 8,
    parameter int DEPTH               = 16,
    parameter int ADDR_WIDTH          = 4,
    parameter int ALMOST_FULL_THRESH  = 14,
    parameter int ALMOST_EMPTY_THRESH = 2,
    parameter bit FWFT                = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_errors
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AF_TH   = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_TH   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESH);

    if (DEPTH != 2**ADDR_WIDTH) begin : g_bad_depth
        $error("DEPTH must equal 2**ADDR_WIDTH");
    end
    if (ALMOST_FULL_THRESH > DEPTH) begin : g_bad_af
        $error("ALMOST_FULL_THRESH must not exceed DEPTH");
    end
    if (ALMOST_EMPTY_THRESH >= DEPTH) begin : g_bad_ae
        $error("ALMOST_EMPTY_THRESH must be below DEPTH");
    end

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  wr_acc;
    logic                  rd_acc;

    assign wr_idx = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_idx = rd_ptr_q[ADDR_WIDTH-1:0];

    // Flags come straight from the registered pointers, so they track post-edge state.
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) && (wr_idx == rd_idx);
    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (count >= AF_TH);
    assign almost_empty = (count <= AE_TH);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = write_en & ~full;
    assign rd_acc = read_en & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        // A new error in the same cycle as clear_errors keeps the flag set.
        overflow_d  = (write_en & full) | (overflow_q & ~clear_errors);
        underflow_d = (read_en & empty) | (underflow_q & ~clear_errors);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wr_idx] <= write_data;
        end
    end

    if (FWFT) begin : g_fwft
        assign read_data  = empty ? '0 : mem_q[rd_idx];
        assign read_valid = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
        logic                  read_valid_q, read_valid_d;

        always_comb begin
            read_data_d  = read_data_q;
            read_valid_d = rd_acc;
            if (rd_acc) begin
                read_data_d = mem_q[rd_idx];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                read_data_q  <= '0;
                read_valid_q <= 1'b0;
            end else begin
                read_data_q  <= read_data_d;
                read_valid_q <= read_valid_d;
            end
        end

        assign read_data  = read_data_q;
        assign read_valid = read_valid_q;
    end

endmodule
